ps2_receiver: RTL and testbench

//  Receives PS/2 keyboard frames (device-to-host) on the ps2_clk/ps2_data pins.

---
 rtl/ps2_receiver.sv | 124 ++++++++++++
 tb/tb_ps2_receiver.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/ps2_receiver.sv
// ps2_receiver: PS/2 device-to-host frame receiver; keeps the two most recent
// valid scan-code bytes with the newest in keycode[7:0].
module ps2_receiver #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 65000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [15:0] keycode,
    output logic        key_valid,
    output logic        frame_err
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FMAX = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0]    clk_sync, data_sync;
    logic          clk_filt, clk_prev, fall, timeout;
    logic [FW-1:0] fcnt;
    logic [TW-1:0] tcnt;
    state_t        state, state_n;
    logic [2:0]    bitcnt, bitcnt_n;
    logic [7:0]    shreg, shreg_n;
    logic          par, par_n, valid_n, err_n;
    logic [15:0]   keycode_n;

    // Synchronize both pins; the clock is debounced so a new level must persist FILTER_LEN samples.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_filt  <= 1'b1;
            clk_prev  <= 1'b1;
            fcnt      <= '0;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            clk_prev  <= clk_filt;
            if (clk_sync[1] == clk_filt) begin
                fcnt <= '0;
            end else if (fcnt == FMAX) begin
                clk_filt <= clk_sync[1];
                fcnt     <= '0;
            end else begin
                fcnt <= fcnt + FW'(1);
            end
        end
    end

    assign fall    = clk_prev & ~clk_filt;
    assign timeout = (state != IDLE) && (tcnt == TMAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            bitcnt    <= '0;
            shreg     <= '0;
            par       <= 1'b0;
            keycode   <= '0;
            key_valid <= 1'b0;
            frame_err <= 1'b0;
            tcnt      <= '0;
        end else begin
            state     <= state_n;
            bitcnt    <= bitcnt_n;
            shreg     <= shreg_n;
            par       <= par_n;
            keycode   <= keycode_n;
            key_valid <= valid_n;
            frame_err <= err_n;
            tcnt      <= (fall || state == IDLE) ? '0 : (tcnt == TMAX ? tcnt : tcnt + TW'(1));
        end
    end

    // A fall always takes priority over a timeout landing in the same cycle.
    always_comb begin
        state_n   = state;
        bitcnt_n  = bitcnt;
        shreg_n   = shreg;
        par_n     = par;
        keycode_n = keycode;
        valid_n   = 1'b0;
        err_n     = 1'b0;
        if (fall) begin
            case (state)
                IDLE: begin
                    if (!data_sync[1]) begin
                        state_n  = DATA;
                        bitcnt_n = '0;
                    end else begin
                        err_n = 1'b1;
                    end
                end
                DATA: begin
                    shreg_n  = {data_sync[1], shreg[7:1]};
                    bitcnt_n = bitcnt + 3'd1;
                    state_n  = (bitcnt == 3'd7) ? PARITY : DATA;
                end
                PARITY: begin
                    par_n   = data_sync[1];
                    state_n = STOP;
                end
                default: begin
                    state_n = IDLE;
                    if (data_sync[1] && ^{shreg, par}) begin
                        keycode_n = {keycode[7:0], shreg};
                        valid_n   = 1'b1;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            endcase
        end else if (timeout) begin
            state_n  = IDLE;
            bitcnt_n = '0;
            err_n    = 1'b1;
        end
    end
endmodule

// File: tb/tb_ps2_receiver.sv
// tb_ps2_receiver: directed PS/2 frames against a frame-level expectation queue;
// a per-cycle monitor matches each output pulse and the keycode history.
module tb_ps2_receiver;
    localparam int FL = 8;
    localparam int TO = 400;
    localparam int H  = 40;

    logic        clk = 1'b0, reset = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
    logic [15:0] keycode;
    logic        key_valid, frame_err;
    int          checks = 0, errors = 0, n_valid = 0, n_err = 0, v0, e0;
    logic [15:0] model_kc = 16'h0000;
    bit          exp_kind[$];
    logic [7:0]  exp_byte[$];

    ps2_receiver #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .keycode(keycode), .key_valid(key_valid), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Data changes while the clock is high; an optional short low glitch sits mid high-phase.
    task automatic send_bit(input logic b, input bit glitch);
        ps2_data = b;
        if (glitch) begin
            tick(20);
            ps2_clk = 1'b0;
            tick(FL - 2);
            ps2_clk = 1'b1;
            tick(H - 20 - (FL - 2));
        end else begin
            tick(H);
        end
        ps2_clk = 1'b0;
        tick(H);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit pflip, input logic stop, input int gbit);
        logic [10:0] bits;
        bits = {stop, ~^b ^ pflip, b, 1'b0};
        exp_kind.push_back(!pflip && stop);
        exp_byte.push_back(b);
        for (int i = 0; i < 11; i++) send_bit(bits[i], i == gbit);
        ps2_data = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && exp_kind.size() != 0; i++) tick(1);
        checks++;
        if (exp_kind.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d events outstanding, expected 0", exp_kind.size());
            exp_kind.delete();
            exp_byte.delete();
        end
        tick(20);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            model_kc = 16'h0000;
            exp_kind.delete();
            exp_byte.delete();
            chk("reset_keycode", keycode, 16'h0000);
            chk("reset_pulses", {14'd0, key_valid, frame_err}, 16'h0000);
        end else begin
            if (key_valid || frame_err) begin
                if (key_valid) n_valid++;
                if (frame_err) n_err++;
                if (exp_kind.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: valid=%b err=%b with none expected", key_valid, frame_err);
                end else begin
                    bit k;
                    logic [7:0] b;
                    k = exp_kind.pop_front();
                    b = exp_byte.pop_front();
                    chk("pulse_kind", {14'd0, key_valid, frame_err}, {14'd0, k, !k});
                    if (k) model_kc = {model_kc[7:0], b};
                end
            end
            chk("keycode_track", keycode, model_kc);
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(5);
        reset = 1'b0;
        tick(5);
        chk("post_reset_keycode", keycode, 16'h0000);
        v0 = n_valid; e0 = n_err;
        send_frame(8'h75, 1'b0, 1'b1, -1);
        drain();
        chk("t1_keycode", keycode, 16'h0075);
        chk("t1_valid_cnt", 16'(n_valid - v0), 16'd1);
        chk("t1_err_cnt", 16'(n_err - e0), 16'd0);
        v0 = n_valid;
        send_frame(8'hE0, 1'b0, 1'b1, -1);
        send_frame(8'h75, 1'b0, 1'b1, -1);
        drain();
        chk("t2_keycode", keycode, 16'hE075);
        chk("t2_valid_cnt", 16'(n_valid - v0), 16'd2);
        v0 = n_valid; e0 = n_err;
        send_frame(8'h72, 1'b1, 1'b1, -1);
        drain();
        chk("t3_keycode", keycode, 16'hE075);
        chk("t3_err_cnt", 16'(n_err - e0), 16'd1);
        chk("t3_valid_cnt", 16'(n_valid - v0), 16'd0);
        e0 = n_err;
        send_frame(8'h6B, 1'b0, 1'b0, -1);
        drain();
        chk("t4_bad_keycode", keycode, 16'hE075);
        chk("t4_err_cnt", 16'(n_err - e0), 16'd1);
        send_frame(8'h6B, 1'b0, 1'b1, -1);
        drain();
        chk("t4_good_keycode", keycode, 16'h756B);
        e0 = n_err;
        exp_kind.push_back(1'b0);
        exp_byte.push_back(8'h00);
        send_bit(1'b1, 1'b0);
        drain();
        chk("false_start_err", 16'(n_err - e0), 16'd1);
        chk("false_start_keycode", keycode, 16'h756B);
        e0 = n_err;
        exp_kind.push_back(1'b0);
        exp_byte.push_back(8'h00);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        tick(TO + 100);
        drain();
        chk("t5_timeout_err", 16'(n_err - e0), 16'd1);
        chk("t5_keycode_hold", keycode, 16'h756B);
        send_frame(8'h75, 1'b0, 1'b1, -1);
        drain();
        chk("t5_recover", keycode, 16'h6B75);
        send_frame(8'h1C, 1'b0, 1'b1, 5);
        drain();
        chk("t6_glitch", keycode, 16'h751C);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        reset = 1'b1;
        tick(3);
        chk("t6_mid_reset_keycode", keycode, 16'h0000);
        reset = 1'b0;
        tick(10);
        send_frame(8'h6B, 1'b0, 1'b1, -1);
        drain();
        chk("t6_after_reset", keycode, 16'h006B);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
